// File: rtl/fft_stage_pkg.sv
// Shared types and index/arithmetic helpers for the folded radix-2 DIT FFT stage.
package fft_stage_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  typedef logic signed [2*MAX_W-1:0] wide_t;

  typedef struct packed {
    wide_t re;
    wide_t im;
  } cplx_wide_t;

  typedef struct packed {
    int unsigned top;
    int unsigned bot;
    int unsigned ix;
  } bfly_idx_t;

  function automatic int unsigned calc_span(input int unsigned stage);
    return 32'd1 << stage;
  endfunction

  function automatic int unsigned calc_c(input int unsigned n_samples, input int unsigned n_bfly);
    return n_samples / (2 * n_bfly);
  endfunction

  // Group/offset split uses shifts since span is always a power of two.
  function automatic bfly_idx_t bfly_index(input int unsigned b, input int unsigned stage,
                                           input int unsigned n_samples);
    bfly_idx_t   r;
    int unsigned span;
    int unsigned j;
    span  = calc_span(stage);
    j     = b & (span - 1);
    r.top = ((b >> stage) << (stage + 1)) + j;
    r.bot = r.top + span;
    r.ix  = j * (n_samples / (2 * span));
    return r;
  endfunction

  // Operands arrive sign-extended; the 2*MAX_W sum wraps exactly like a 2*BIT_WIDTH one
  // in the bits that survive the shift and truncation.
  function automatic cplx_wide_t cmul_fx(input wide_t ar, input wide_t ai,
                                         input wide_t br, input wide_t bi,
                                         input int unsigned frac);
    cplx_wide_t r;
    wide_t      re;
    wide_t      im;
    re   = ar * br - ai * bi;
    im   = ar * bi + ai * br;
    r.re = re >>> frac;
    r.im = im >>> frac;
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_lane.sv
// One radix-2 butterfly lane: twiddle lookup from the sine table, complex multiply,
// and the sum/difference outputs.
module fft_bfly_lane
  import fft_stage_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned DECIMAL_PT = 16,
  parameter int unsigned N_SAMPLES  = 8,
  parameter int unsigned INVERSE    = 0
) (
  input  logic [$clog2(N_SAMPLES)-1:0] ix,
  input  logic [BIT_WIDTH-1:0]         sine [N_SAMPLES],
  input  logic [BIT_WIDTH-1:0]         top_real,
  input  logic [BIT_WIDTH-1:0]         top_imag,
  input  logic [BIT_WIDTH-1:0]         bot_real,
  input  logic [BIT_WIDTH-1:0]         bot_imag,
  output logic [BIT_WIDTH-1:0]         sum_real,
  output logic [BIT_WIDTH-1:0]         sum_imag,
  output logic [BIT_WIDTH-1:0]         diff_real,
  output logic [BIT_WIDTH-1:0]         diff_imag
);

  localparam int unsigned IW = $clog2(N_SAMPLES);

  logic [IW-1:0]               cos_ix;
  logic signed [BIT_WIDTH-1:0] w_real;
  logic signed [BIT_WIDTH-1:0] w_imag;
  logic signed [BIT_WIDTH-1:0] x_real;
  logic signed [BIT_WIDTH-1:0] x_imag;
  logic signed [BIT_WIDTH-1:0] t_real;
  logic signed [BIT_WIDTH-1:0] t_imag;
  cplx_wide_t                  prod;
  logic                        unused_prod;

  always_comb begin
    // Cosine is the sine table read a quarter period ahead, wrapping modulo N.
    cos_ix    = ix + IW'(N_SAMPLES / 4);
    w_real    = sine[cos_ix];
    w_imag    = (INVERSE != 0) ? sine[ix] : -sine[ix];
    x_real    = bot_real;
    x_imag    = bot_imag;
    prod      = cmul_fx(wide_t'(w_real), wide_t'(w_imag), wide_t'(x_real), wide_t'(x_imag),
                        DECIMAL_PT);
    t_real    = prod.re[BIT_WIDTH-1:0];
    t_imag    = prod.im[BIT_WIDTH-1:0];
    sum_real  = top_real + t_real;
    sum_imag  = top_imag + t_imag;
    diff_real = top_real - t_real;
    diff_imag = top_imag - t_imag;
  end

  assign unused_prod = ^{prod.re[2*MAX_W-1:BIT_WIDTH], prod.im[2*MAX_W-1:BIT_WIDTH]};

endmodule

// File: rtl/fft_stage_folded.sv
// Time-multiplexed radix-2 DIT FFT stage: N_BFLY lanes sweep the buffered frame in place,
// framed by valid/ready handshakes on both sides.
module fft_stage_folded
  import fft_stage_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned DECIMAL_PT = 16,
  parameter int unsigned N_SAMPLES  = 8,
  parameter int unsigned STAGE_FFT  = 0,
  parameter int unsigned N_BFLY     = 1,
  parameter int unsigned INVERSE    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg_real [N_SAMPLES],
  input  logic [BIT_WIDTH-1:0] recv_msg_imag [N_SAMPLES],
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg_real [N_SAMPLES],
  output logic [BIT_WIDTH-1:0] send_msg_imag [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy,
  input  logic [BIT_WIDTH-1:0] sine_wave_out [N_SAMPLES]
);

  localparam int unsigned C  = calc_c(N_SAMPLES, N_BFLY);
  localparam int unsigned CW = $clog2(C + 1);
  localparam int unsigned IW = $clog2(N_SAMPLES);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic                 issue;
  logic                 capture;
  logic [BIT_WIDTH-1:0] frame_real [N_SAMPLES];
  logic [BIT_WIDTH-1:0] frame_imag [N_SAMPLES];

  bfly_idx_t            lane_idx  [N_BFLY];
  logic [IW-1:0]        top_ix    [N_BFLY];
  logic [IW-1:0]        bot_ix    [N_BFLY];
  logic [IW-1:0]        tw_ix     [N_BFLY];
  logic                 unused_idx;
  logic [BIT_WIDTH-1:0] sum_real  [N_BFLY];
  logic [BIT_WIDTH-1:0] sum_imag  [N_BFLY];
  logic [BIT_WIDTH-1:0] diff_real [N_BFLY];
  logic [BIT_WIDTH-1:0] diff_imag [N_BFLY];

  logic                 wb_val;
  logic [IW-1:0]        wb_top_ix    [N_BFLY];
  logic [IW-1:0]        wb_bot_ix    [N_BFLY];
  logic [BIT_WIDTH-1:0] wb_sum_real  [N_BFLY];
  logic [BIT_WIDTH-1:0] wb_sum_imag  [N_BFLY];
  logic [BIT_WIDTH-1:0] wb_diff_real [N_BFLY];
  logic [BIT_WIDTH-1:0] wb_diff_imag [N_BFLY];

  assign issue   = (state == COMPUTE) && (cnt != CW'(C));
  assign capture = recv_val && recv_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // COMPUTE runs one extra cycle past the last issue to drain the write-back register.
  always_comb begin
    state_nxt = state;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    case (state)
      IDLE: begin
        recv_rdy = reset;
        if (recv_val) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (cnt == CW'(C)) state_nxt = DONE;
      end
      DONE: begin
        send_val = 1'b1;
        recv_rdy = send_rdy;
        if (send_rdy) state_nxt = recv_val ? COMPUTE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unused_idx = 1'b0;
    for (int unsigned l = 0; l < N_BFLY; l++) begin
      lane_idx[l] = bfly_index(32'(cnt) * N_BFLY + l, STAGE_FFT, N_SAMPLES);
      top_ix[l]   = IW'(lane_idx[l].top);
      bot_ix[l]   = IW'(lane_idx[l].bot);
      tw_ix[l]    = IW'(lane_idx[l].ix);
      unused_idx  = unused_idx ^ (^{lane_idx[l].top[31:IW], lane_idx[l].bot[31:IW],
                                    lane_idx[l].ix[31:IW]});
    end
  end

  for (genvar l = 0; l < N_BFLY; l++) begin : g_lane
    fft_bfly_lane #(
      .BIT_WIDTH (BIT_WIDTH),
      .DECIMAL_PT(DECIMAL_PT),
      .N_SAMPLES (N_SAMPLES),
      .INVERSE   (INVERSE)
    ) u_lane (
      .ix       (tw_ix[l]),
      .sine     (sine_wave_out),
      .top_real (frame_real[top_ix[l]]),
      .top_imag (frame_imag[top_ix[l]]),
      .bot_real (frame_real[bot_ix[l]]),
      .bot_imag (frame_imag[bot_ix[l]]),
      .sum_real (sum_real[l]),
      .sum_imag (sum_imag[l]),
      .diff_real(diff_real[l]),
      .diff_imag(diff_imag[l])
    );
  end

  // Results land one cycle after their reads; butterflies of one stage touch disjoint
  // elements, so the next read never needs a value still in the write-back register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      wb_val <= 1'b0;
      for (int unsigned i = 0; i < N_SAMPLES; i++) begin
        frame_real[i] <= '0;
        frame_imag[i] <= '0;
      end
      for (int unsigned l = 0; l < N_BFLY; l++) begin
        wb_top_ix[l]    <= '0;
        wb_bot_ix[l]    <= '0;
        wb_sum_real[l]  <= '0;
        wb_sum_imag[l]  <= '0;
        wb_diff_real[l] <= '0;
        wb_diff_imag[l] <= '0;
      end
    end else begin
      wb_val <= issue;
      if (capture) begin
        frame_real <= recv_msg_real;
        frame_imag <= recv_msg_imag;
        cnt        <= '0;
      end else if (issue) begin
        cnt <= cnt + CW'(1);
        for (int unsigned l = 0; l < N_BFLY; l++) begin
          wb_top_ix[l]    <= top_ix[l];
          wb_bot_ix[l]    <= bot_ix[l];
          wb_sum_real[l]  <= sum_real[l];
          wb_sum_imag[l]  <= sum_imag[l];
          wb_diff_real[l] <= diff_real[l];
          wb_diff_imag[l] <= diff_imag[l];
        end
      end
      if (wb_val) begin
        for (int unsigned l = 0; l < N_BFLY; l++) begin
          frame_real[wb_top_ix[l]] <= wb_sum_real[l];
          frame_imag[wb_top_ix[l]] <= wb_sum_imag[l];
          frame_real[wb_bot_ix[l]] <= wb_diff_real[l];
          frame_imag[wb_bot_ix[l]] <= wb_diff_imag[l];
        end
      end
    end
  end

  assign send_msg_real = frame_real;
  assign send_msg_imag = frame_imag;

endmodule

// File: tb/tb_fft_stage_folded.sv
// Directed and randomized checks of fft_stage_folded across several stage/lane/inverse
// configurations, against a pair-wise butterfly model of the stage.
module tb_fft_stage_folded;

  localparam int unsigned W  = 32;
  localparam int unsigned FR = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned ND = 5;
  localparam int unsigned STG [ND] = '{0, 2, 2, 2, 1};
  localparam int unsigned NBF [ND] = '{1, 4, 2, 2, 1};
  localparam int unsigned INV [ND] = '{0, 0, 0, 1, 1};
  localparam logic [W-1:0] ONE  = 32'h0001_0000;
  localparam logic [W-1:0] MONE = 32'hFFFF_0000;
  localparam logic [W-1:0] R2   = 32'h0000_B504;
  localparam logic [W-1:0] NR2  = 32'hFFFF_4AFC;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  sine   [N];
  logic [W-1:0]  in_re  [N];
  logic [W-1:0]  in_im  [N];
  logic [ND-1:0] rv = '0;
  logic [ND-1:0] sr = '0;
  logic [ND-1:0] rr;
  logic [ND-1:0] sv;
  logic [W-1:0]  out_re [ND][N];
  logic [W-1:0]  out_im [ND][N];
  logic [W-1:0]  exp_re [N];
  logic [W-1:0]  exp_im [N];
  int unsigned   n_cmp  = 0;
  int unsigned   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    fft_stage_folded #(
      .BIT_WIDTH (W),
      .DECIMAL_PT(FR),
      .N_SAMPLES (N),
      .STAGE_FFT (STG[d]),
      .N_BFLY    (NBF[d]),
      .INVERSE   (INV[d])
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .recv_msg_real(in_re),
      .recv_msg_imag(in_im),
      .recv_val     (rv[d]),
      .recv_rdy     (rr[d]),
      .send_msg_real(out_re[d]),
      .send_msg_imag(out_im[d]),
      .send_val     (sv[d]),
      .send_rdy     (sr[d]),
      .sine_wave_out(sine)
    );
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_frame(input int d, input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s dut%0d re[%0d]", tag, d, i), out_re[d][i], exp_re[i]);
      check($sformatf("%s dut%0d im[%0d]", tag, d, i), out_im[d][i], exp_im[i]);
    end
  endtask

  task automatic zero_all();
    for (int i = 0; i < N; i++) begin
      in_re[i] = '0; in_im[i] = '0; exp_re[i] = '0; exp_im[i] = '0;
    end
  endtask

  task automatic rand_in();
    for (int i = 0; i < N; i++) begin
      in_re[i] = $urandom;
      in_im[i] = $urandom;
    end
  endtask

  // Reference: walk every (top, top+span) pair of the stage with 64-bit integer arithmetic.
  task automatic model(input int d);
    int unsigned  span, bot, k;
    longint       wr, wi, br, bi, pr, pi;
    logic [W-1:0] tr, ti;
    for (int i = 0; i < N; i++) begin
      exp_re[i] = in_re[i];
      exp_im[i] = in_im[i];
    end
    span = 1 << STG[d];
    for (int unsigned top = 0; top < N; top++) begin
      if (((top / span) % 2) == 0) begin
        bot = top + span;
        k   = (top % span) * (N / (2 * span));
        wr  = $signed(sine[(k + N / 4) % N]);
        wi  = $signed(sine[k]);
        if (INV[d] == 0) wi = -wi;
        br  = $signed(in_re[bot]);
        bi  = $signed(in_im[bot]);
        pr  = (wr * br - wi * bi) >>> FR;
        pi  = (wr * bi + wi * br) >>> FR;
        tr  = pr[W-1:0];
        ti  = pi[W-1:0];
        exp_re[top] = in_re[top] + tr;
        exp_im[top] = in_im[top] + ti;
        exp_re[bot] = in_re[top] - tr;
        exp_im[bot] = in_im[top] - ti;
      end
    end
  endtask

  // Returns #1 after the edge at which the frame was captured.
  task automatic push(input int d);
    int unsigned k = 0;
    rv[d] = 1'b1;
    while (!rr[d] && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("accept dut%0d", d), W'(rr[d]), W'(1));
    @(posedge clk); #1;
    rv[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input string tag);
    int unsigned lat = 0;
    while (!sv[d] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s dut%0d latency", tag, d), W'(lat), W'(N / (2 * NBF[d]) + 1));
  endtask

  task automatic pop(input int d);
    sr[d] = 1'b1;
    @(posedge clk); #1;
    sr[d] = 1'b0;
    check($sformatf("pop dut%0d send_val", d), W'(sv[d]), W'(0));
    check($sformatf("pop dut%0d recv_rdy", d), W'(rr[d]), W'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sine = '{32'h0, R2, ONE, R2, 32'h0, NR2, MONE, NR2};
    zero_all();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset recv_rdy", W'(rr), W'(0));
    check("reset send_val", W'(sv), W'(0));
    check_frame(0, "reset frame");
    reset = 1'b1;
    #1;
    check("post-reset recv_rdy", W'(rr), W'({ND{1'b1}}));

    // Stage 0, one lane: ramp 1..8
    for (int i = 0; i < N; i++) in_re[i] = W'((i + 1) * 65536);
    for (int i = 0; i < N; i++) exp_re[i] = (i % 2 == 0) ? W'((2 * i + 3) * 65536) : MONE;
    push(0);
    wait_done(0, "ramp");
    check_frame(0, "ramp");
    pop(0);

    // Overflow wraps without saturation
    zero_all();
    in_re[0]  = 32'h7FFF_0000;
    in_re[1]  = ONE;
    exp_re[0] = 32'h8000_0000;
    exp_re[1] = 32'h7FFE_0000;
    push(0);
    wait_done(0, "wrap");
    check_frame(0, "wrap");
    pop(0);

    // Stage 2, four lanes: single cycle of butterflies
    zero_all();
    in_re[0]  = ONE;
    in_re[4]  = ONE;
    exp_re[0] = 32'h0002_0000;
    push(1);
    wait_done(1, "pair");
    check_frame(1, "pair");
    pop(1);

    // Stage 2, two lanes: 45-degree twiddle, forward then inverse
    zero_all();
    in_re[5]  = ONE;
    exp_re[1] = R2;  exp_im[1] = NR2;
    exp_re[5] = NR2; exp_im[5] = R2;
    push(2);
    wait_done(2, "tw45");
    check_frame(2, "tw45");
    pop(2);
    exp_re[1] = R2;  exp_im[1] = R2;
    exp_re[5] = NR2; exp_im[5] = NR2;
    push(3);
    wait_done(3, "tw45 inv");
    check_frame(3, "tw45 inv");
    pop(3);

    // Backpressure holds the result, then a back-to-back frame is taken on release
    rand_in();
    model(0);
    push(0);
    wait_done(0, "bp1");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp send_val", W'(sv[0]), W'(1));
      check("bp recv_rdy", W'(rr[0]), W'(0));
      check_frame(0, "bp hold");
    end
    rand_in();
    model(0);
    rv[0] = 1'b1;
    sr[0] = 1'b1;
    #1;
    check("b2b recv_rdy", W'(rr[0]), W'(1));
    @(posedge clk); #1;
    rv[0] = 1'b0;
    sr[0] = 1'b0;
    wait_done(0, "b2b");
    check_frame(0, "b2b");
    pop(0);

    // Reset during COMPUTE discards the frame
    rand_in();
    push(0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst send_val", W'(sv[0]), W'(0));
    check("rst recv_rdy", W'(rr[0]), W'(0));
    zero_all();
    check_frame(0, "rst cleared");
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst release recv_rdy", W'(rr[0]), W'(1));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("rst quiet send_val", W'(sv), W'(0));
    end
    rand_in();
    model(0);
    push(0);
    wait_done(0, "after rst");
    check_frame(0, "after rst");
    pop(0);

    // Randomized frames with random output stalls on every configuration
    for (int d = 0; d < ND; d++) begin
      for (int f = 0; f < 4; f++) begin
        rand_in();
        model(d);
        push(d);
        wait_done(d, "rand");
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        check_frame(d, "rand");
        pop(d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
